// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides, full N/Z/C/V flags
// and a stored carry that chains multi-word ADC/SBB sequences.
module alu_pipe #(
    parameter int DATA_WIDTH  = 8,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            OPCODE,
    input  logic [DATA_WIDTH-1:0] OP1,
    input  logic [DATA_WIDTH-1:0] OP2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] RESULT,
    output logic                  CARRY,
    output logic                  ZERO,
    output logic                  NEG,
    output logic                  OVF,
    output logic                  ILLEGAL
);
    localparam int W = DATA_WIDTH;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_INC  = 4'd2;
    localparam logic [3:0] OP_DEC  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_NAND = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_ASR  = 4'd10;
    localparam logic [3:0] OP_CMP  = 4'd11;
    localparam logic [3:0] OP_ADC  = 4'd12;
    localparam logic [3:0] OP_SBB  = 4'd13;
    localparam logic [3:0] OP_PASS = 4'd14;

    logic                   r_s1_valid;
    logic [3:0]             r_s1_op;
    logic [W-1:0]           r_s1_a;
    logic [W-1:0]           r_s1_b;
    logic                   r_s2_valid;
    logic [W-1:0]           r_result;
    logic                   r_carry;
    logic                   r_zero;
    logic                   r_neg;
    logic                   r_ovf;
    logic                   r_ill;
    logic                   r_carry_q;

    logic                   w_s2_free;
    logic                   w_in_ready;
    logic                   w_accept;
    logic                   w_xfer;
    logic [SHAMT_WIDTH-1:0] w_sh;
    logic [W-1:0]           w_opnd_b;
    logic                   w_cin;
    logic [W:0]             w_sum;
    logic [W:0]             w_diff;
    logic                   w_add_v;
    logic                   w_sub_v;
    logic [W:0]             w_shl;
    logic [W:0]             w_shr;
    logic [W:0]             w_asr;
    logic [W-1:0]           w_res;
    logic                   w_c;
    logic                   w_v;
    logic                   w_ill;
    logic                   w_upd_c;

    // flush wins over any same-cycle accept or transfer, even though in_ready may read 1
    assign w_s2_free  = !r_s2_valid || out_ready;
    assign w_in_ready = !r_s1_valid || w_s2_free;
    assign w_accept   = in_valid && w_in_ready && !flush;
    assign w_xfer     = r_s1_valid && w_s2_free && !flush;

    // One shared adder/subtractor serves ADD/INC/ADC and SUB/DEC/CMP/SBB
    assign w_opnd_b = (r_s1_op == OP_INC || r_s1_op == OP_DEC) ? {{(W-1){1'b0}}, 1'b1} : r_s1_b;
    assign w_cin    = (r_s1_op == OP_ADC || r_s1_op == OP_SBB) ? r_carry_q : 1'b0;
    assign w_sum    = {1'b0, r_s1_a} + {1'b0, w_opnd_b} + {{W{1'b0}}, w_cin};
    assign w_diff   = {1'b0, r_s1_a} - {1'b0, w_opnd_b} - {{W{1'b0}}, w_cin};
    assign w_add_v  = (r_s1_a[W-1] == w_opnd_b[W-1]) && (w_sum[W-1] != r_s1_a[W-1]);
    assign w_sub_v  = (r_s1_a[W-1] != w_opnd_b[W-1]) && (w_diff[W-1] != r_s1_a[W-1]);

    // Extra guard bit on each shift catches the last bit shifted out (0 when sh==0)
    assign w_sh  = r_s1_b[SHAMT_WIDTH-1:0];
    assign w_shl = {1'b0, r_s1_a} << w_sh;
    assign w_shr = {r_s1_a, 1'b0} >> w_sh;
    assign w_asr = $unsigned($signed({r_s1_a, 1'b0}) >>> w_sh);

    always_comb begin
        w_res   = '0;
        w_c     = 1'b0;
        w_v     = 1'b0;
        w_ill   = 1'b0;
        w_upd_c = 1'b0;
        case (r_s1_op)
            OP_ADD, OP_INC, OP_ADC: begin
                {w_c, w_res} = w_sum;
                w_v          = w_add_v;
                w_upd_c      = 1'b1;
            end
            OP_SUB, OP_DEC, OP_SBB: begin
                {w_c, w_res} = w_diff;
                w_v          = w_sub_v;
                w_upd_c      = 1'b1;
            end
            OP_CMP: begin
                w_res = r_s1_a;
                w_c   = w_diff[W];
                w_v   = w_sub_v;
            end
            OP_AND:  w_res = r_s1_a & r_s1_b;
            OP_OR:   w_res = r_s1_a | r_s1_b;
            OP_NAND: w_res = ~(r_s1_a & r_s1_b);
            OP_XOR:  w_res = r_s1_a ^ r_s1_b;
            OP_SHL: begin
                {w_c, w_res} = w_shl;
                w_upd_c      = 1'b1;
            end
            OP_SHR: begin
                {w_res, w_c} = w_shr;
                w_upd_c      = 1'b1;
            end
            OP_ASR: begin
                {w_res, w_c} = w_asr;
                w_upd_c      = 1'b1;
            end
            OP_PASS: w_res = r_s1_a;
            default: w_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_zero     <= 1'b0;
            r_neg      <= 1'b0;
            r_ovf      <= 1'b0;
            r_ill      <= 1'b0;
            r_carry_q  <= 1'b0;
        end else begin
            if (flush) begin
                r_s1_valid <= 1'b0;
                r_s2_valid <= 1'b0;
                r_carry_q  <= 1'b0;
            end else begin
                if (w_in_ready) begin
                    r_s1_valid <= in_valid;
                end
                if (w_s2_free) begin
                    r_s2_valid <= r_s1_valid;
                end
                if (w_xfer && w_upd_c) begin
                    r_carry_q <= w_c;
                end
            end
            if (w_accept) begin
                r_s1_op <= OPCODE;
                r_s1_a  <= OP1;
                r_s1_b  <= OP2;
            end
            if (w_xfer) begin
                r_result <= w_res;
                r_carry  <= w_c;
                r_zero   <= (w_res == '0);
                r_neg    <= w_res[W-1];
                r_ovf    <= w_v;
                r_ill    <= w_ill;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_s2_valid;
    assign RESULT    = r_result;
    assign CARRY     = r_carry;
    assign ZERO      = r_zero;
    assign NEG       = r_neg;
    assign OVF       = r_ovf;
    assign ILLEGAL   = r_ill;

endmodule
